// File: rtl/gshare_pht.sv
// gshare pattern history table: 2-bit saturating counters indexed by PC XOR
// global history, with same-cycle update bypass, history-register forwarding
// and saturating performance counters.
module gshare_pht #(
   parameter int unsigned IDX_BITS  = 7,
   parameter int unsigned HIST_BITS = 1,
   parameter int unsigned PC_LSB    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HIST_BITS-1:0] hist_i,
   input  logic                 rd_valid_i,
   input  logic [31:0]          rd_pc_i,
   output logic                 pred_taken_o,
   output logic [IDX_BITS-1:0]  pred_idx_o,
   input  logic                 upd_valid_i,
   input  logic [IDX_BITS-1:0]  upd_idx_i,
   input  logic                 upd_taken_i,
   input  logic                 upd_pred_i,
   output logic                 ghr_load_o,
   output logic                 ghr_taken_o,
   output logic                 mispredict_o,
   output logic [31:0]          perf_pred_cnt_o,
   output logic [31:0]          perf_miss_cnt_o
);

   localparam int unsigned DEPTH   = 1 << IDX_BITS;
   localparam int unsigned CNT_W   = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]          pht [DEPTH];
   logic [IDX_BITS-1:0] rd_idx;
   logic [1:0]          rd_cur;
   logic [1:0]          upd_cur;
   logic [1:0]          upd_nxt;
   logic                unused_pc;

   // Only the indexing slice of the PC matters; the remaining bits are ignored.
   assign unused_pc = ^rd_pc_i;

   assign rd_idx     = rd_pc_i[PC_LSB +: IDX_BITS] ^ IDX_BITS'(hist_i);
   assign pred_idx_o = rd_idx;
   assign rd_cur     = pht[rd_idx];
   assign upd_cur    = pht[upd_idx_i];

   assign ghr_load_o   = upd_valid_i;
   assign ghr_taken_o  = upd_taken_i;
   assign mispredict_o = upd_valid_i & (upd_taken_i != upd_pred_i);

   // Saturating next value of the entry being trained.
   always_comb begin
      upd_nxt = upd_cur;
      if (upd_taken_i) begin
         if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'd1;
      end else begin
         if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'd1;
      end
   end

   // Prediction is the counter MSB, bypassing a same-index update in flight.
   always_comb begin
      pred_taken_o = rd_cur[1];
      if (upd_valid_i && (upd_idx_i == rd_idx)) pred_taken_o = upd_nxt[1];
   end

   // Table storage: clear on reset, otherwise write back one trained entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) pht[i] <= 2'b00;
      end else if (upd_valid_i) begin
         pht[upd_idx_i] <= upd_nxt;
      end
   end

   // Saturating performance counters for predictions issued and mispredicts.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_pred_cnt_o <= '0;
         perf_miss_cnt_o <= '0;
      end else begin
         if (rd_valid_i && (perf_pred_cnt_o != CNT_MAX))
            perf_pred_cnt_o <= perf_pred_cnt_o + CNT_W'(1);
         if (mispredict_o && (perf_miss_cnt_o != CNT_MAX))
            perf_miss_cnt_o <= perf_miss_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed vector table plus randomized
// traffic against an array-based reference model.
module tb_gshare_pht;

   localparam int IDX_BITS = 7;
   localparam int DEPTH    = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:0]  hist;
   logic        rd_valid;
   logic [31:0] rd_pc;
   logic        pred_taken;
   logic [6:0]  pred_idx;
   logic        upd_valid;
   logic [6:0]  upd_idx;
   logic        upd_taken;
   logic        upd_pred;
   logic        ghr_load;
   logic        ghr_taken;
   logic        mispredict;
   logic [31:0] perf_pred_cnt;
   logic [31:0] perf_miss_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int     m_tab [DEPTH];
   longint m_pred_cnt;
   longint m_miss_cnt;

   always #5 clk = ~clk;

   gshare_pht #(.IDX_BITS(IDX_BITS), .HIST_BITS(1), .PC_LSB(2)) dut (
      .clk(clk), .rst(rst), .hist_i(hist), .rd_valid_i(rd_valid), .rd_pc_i(rd_pc),
      .pred_taken_o(pred_taken), .pred_idx_o(pred_idx),
      .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
      .upd_pred_i(upd_pred), .ghr_load_o(ghr_load), .ghr_taken_o(ghr_taken),
      .mispredict_o(mispredict), .perf_pred_cnt_o(perf_pred_cnt),
      .perf_miss_cnt_o(perf_miss_cnt)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        hist;
      logic        rdv;
      logic        uv;
      logic [6:0]  ui;
      logic        ut;
      logic        up;
      logic        exp_pred;
      logic [6:0]  exp_idx;
      logic        exp_miss;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat_step(input int v, input logic taken);
      if (taken) return (v >= 3) ? 3 : v + 1;
      return (v <= 0) ? 0 : v - 1;
   endfunction

   function automatic int model_idx(input logic [31:0] pc, input logic h);
      return ((pc / 4) % DEPTH) ^ int'(h);
   endfunction

   function automatic logic model_pred(input logic [31:0] pc, input logic h,
                                       input logic uv, input logic [6:0] ui,
                                       input logic ut);
      int idx = model_idx(pc, h);
      if (uv && int'(ui) == idx) return sat_step(m_tab[idx], ut) >= 2;
      return m_tab[idx] >= 2;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
         m_pred_cnt = 0;
         m_miss_cnt = 0;
      end else begin
         if (upd_valid) m_tab[upd_idx] = sat_step(m_tab[upd_idx], upd_taken);
         if (rd_valid && m_pred_cnt < 64'hFFFF_FFFF) m_pred_cnt++;
         if (upd_valid && upd_taken != upd_pred && m_miss_cnt < 64'hFFFF_FFFF) m_miss_cnt++;
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] pc, input logic h,
                        input logic rdv, input logic uv, input logic [6:0] ui,
                        input logic ut, input logic up);
      rst = r; rd_pc = pc; hist = h; rd_valid = rdv;
      upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
   endtask

   // Compare everything against the model; called at the negedge.
   task automatic check_model(input string tag);
      chk({tag, " idx"},  32'(pred_idx), 32'(model_idx(rd_pc, hist)));
      chk({tag, " pred"}, 32'(pred_taken),
          32'(model_pred(rd_pc, hist, upd_valid, upd_idx, upd_taken)));
      chk({tag, " miss"}, 32'(mispredict), 32'(upd_valid && (upd_taken != upd_pred)));
      chk({tag, " ghr_load"},  32'(ghr_load),  32'(upd_valid));
      chk({tag, " ghr_taken"}, 32'(ghr_taken), 32'(upd_taken));
      chk({tag, " perf_pred"}, perf_pred_cnt, 32'(m_pred_cnt));
      chk({tag, " perf_miss"}, perf_miss_cnt, 32'(m_miss_cnt));
   endtask

   vec_t vecs [$];

   initial begin
      // rst pc hist rdv uv ui ut up | pred idx miss
      vecs.push_back('{0, 32'h40, 1, 0, 0, 7'h00, 0, 0, 0, 7'h11, 0}); // after reset
      vecs.push_back('{0, 32'h40, 1, 1, 1, 7'h11, 1, 0, 0, 7'h11, 1}); // 00->01 bypass
      vecs.push_back('{0, 32'h40, 1, 1, 0, 7'h00, 0, 0, 0, 7'h11, 0}); // reads 01
      vecs.push_back('{0, 32'h40, 1, 1, 1, 7'h11, 1, 0, 1, 7'h11, 1}); // 01->10 bypass
      vecs.push_back('{0, 32'h40, 1, 0, 0, 7'h00, 0, 0, 1, 7'h11, 0}); // reads 10
      vecs.push_back('{0, 32'h48, 0, 0, 1, 7'h11, 1, 1, 0, 7'h12, 0}); // other idx clean
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 1, 1, 0, 7'h05, 0}); // 00->01
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 1, 1, 1, 7'h05, 0}); // 01->10
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 1, 1, 1, 7'h05, 0}); // 10->11
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 1, 1, 1, 7'h05, 0}); // 11 saturates
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 0, 1, 1, 7'h05, 1}); // 11->10
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 0, 0, 0, 7'h05, 0}); // 10->01
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 0, 0, 0, 7'h05, 0}); // 01->00
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 0, 0, 0, 7'h05, 0}); // 00 saturates
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 0, 0, 0, 7'h05, 0});
      vecs.push_back('{0, 32'h14, 0, 0, 1, 7'h05, 0, 0, 0, 7'h05, 0});
      vecs.push_back('{0, 32'h40, 1, 0, 0, 7'h00, 0, 0, 1, 7'h11, 0}); // idx 0x11 at 11
      vecs.push_back('{1, 32'h40, 1, 0, 1, 7'h11, 1, 1, 1, 7'h11, 0}); // reset + update
      vecs.push_back('{0, 32'h40, 1, 0, 0, 7'h00, 0, 0, 0, 7'h11, 0}); // state discarded

      drive(1, 32'h0, 0, 0, 0, 7'h0, 0, 0);
      for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
      m_pred_cnt = 0;
      m_miss_cnt = 0;
      @(posedge clk); #1;
      drive(1, 32'h0, 0, 0, 0, 7'h0, 0, 0);
      @(posedge clk); #1;

      // Directed table
      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].pc, vecs[k].hist, vecs[k].rdv, vecs[k].uv,
               vecs[k].ui, vecs[k].ut, vecs[k].up);
         @(negedge clk);
         chk($sformatf("vec%0d pred", k), 32'(pred_taken), 32'(vecs[k].exp_pred));
         chk($sformatf("vec%0d idx", k),  32'(pred_idx),   32'(vecs[k].exp_idx));
         chk($sformatf("vec%0d miss", k), 32'(mispredict), 32'(vecs[k].exp_miss));
         check_model($sformatf("vec%0d", k));
         model_edge();
         @(posedge clk); #1;
      end

      // Explicit counter sequence: one mispredict, then three prediction cycles
      drive(0, 32'h0, 0, 0, 1, 7'h33, 1, 0);
      @(negedge clk);
      chk("seq miss comb", 32'(mispredict), 32'd1);
      model_edge();
      @(posedge clk); #1;
      chk("seq miss cnt", perf_miss_cnt, 32'd1);
      for (int c = 0; c < 3; c++) begin
         drive(0, 32'h100, 0, 1, 0, 7'h0, 0, 0);
         model_edge();
         @(posedge clk); #1;
      end
      chk("seq pred cnt", perf_pred_cnt, 32'd3);

      // Randomized traffic with frequent index collisions
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc;
         logic [6:0]  ui;
         pc = $urandom;
         if ($urandom_range(1, 0) == 1) pc[8:2] = 7'($urandom_range(7, 0));
         ui = ($urandom_range(1, 0) == 1) ? 7'(model_idx(pc, 1'b0)) ^ 7'($urandom_range(1, 0))
                                         : 7'($urandom_range(7, 0));
         drive(($urandom_range(79, 0) == 0), pc, 1'($urandom), 1'($urandom),
               1'($urandom), ui, 1'($urandom), 1'($urandom));
         @(negedge clk);
         check_model($sformatf("rnd%0d", n));
         model_edge();
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
Pattern history table of 2-bit saturating counters for the gshare branch predictor.
- Sits directly downstream of the global history register. Consumes its history index and combines it with the fetch PC to produce a taken/not-taken prediction for IF.
- Accepts resolved-branch updates from EX. Forwards the same resolved outcome to the history register as its load/taken inputs, so both structures train on the same clock edge.
- Keeps saturating prediction and mispredict counters for performance analysis.

Parameters:
- IDX_BITS, 7, log2 of table depth (128 entries).
- HIST_BITS, 1, history register width; must satisfy 1 <= HIST_BITS <= IDX_BITS.
- PC_LSB, 2, lowest PC bit used for indexing; PC bits below it are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hist_i  in  HIST_BITS  global history from the history register index output
- rd_valid_i  in  1  IF is requesting a prediction this cycle
- rd_pc_i  in  32  fetch PC
- pred_taken_o  out  1  prediction: 1 = taken
- pred_idx_o  out  IDX_BITS  table index used; carried down the pipeline to EX
- upd_valid_i  in  1  EX has resolved a branch this cycle
- upd_idx_i  in  IDX_BITS  index carried from prediction time
- upd_taken_i  in  1  actual outcome
- upd_pred_i  in  1  prediction made for this branch
- ghr_load_o  out  1  drives the history register load input
- ghr_taken_o  out  1  drives the history register taken input
- mispredict_o  out  1  resolved branch was mispredicted
- perf_pred_cnt_o  out  32  count of predictions issued
- perf_miss_cnt_o  out  32  count of mispredicts

Behaviour:
- Index: pred_idx_o = rd_pc_i[PC_LSB+IDX_BITS-1:PC_LSB] XOR zero-extended hist_i. Combinational, computed regardless of rd_valid_i.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction is the counter MSB.
- Read: combinational, zero latency. pred_taken_o is valid in the same cycle as rd_pc_i/hist_i.
- Bypass: if upd_valid_i=1 and upd_idx_i equals the read index in the same cycle, pred_taken_o reflects the post-update counter value.
- Update: on posedge clk when upd_valid_i=1 and rst=0:
  - upd_taken_i=1: counter increments, saturating at 11.
  - upd_taken_i=0: counter decrements, saturating at 00.
  - Exactly one entry changes per cycle.
- History forwarding (combinational pass-through, so the history register shifts on the same edge as the table update):
  - ghr_load_o = upd_valid_i
  - ghr_taken_o = upd_taken_i
- Mispredict: mispredict_o = upd_valid_i & (upd_taken_i != upd_pred_i). Combinational.
- Performance counters:
  - perf_pred_cnt_o increments on each edge where rd_valid_i=1.
  - perf_miss_cnt_o increments on each edge where mispredict_o=1.
  - Both saturate at 32'hFFFF_FFFF; they never wrap.
- Reset: one cycle with rst=1 sets every entry to 00 and both perf counters to 0.
  - An update presented during a reset cycle is dropped.
  - Reset asserted mid-training discards all state.
  - Combinational outputs are valid during reset; pred_taken_o reads the current table with bypass applied.
- Simultaneous read and update to different indices: fully independent; the read sees the pre-edge value.

Test Plan:
- Reset, then read with rd_pc_i=0x0000_0040, hist_i=1 -> pred_idx_o=0x11, pred_taken_o=0; both perf counters 0.
- Two taken updates to idx 0x11 on consecutive cycles -> entry 00->01->10; read of idx 0x11 returns 0 after the first edge and 1 after the second.
- Four taken updates then one not-taken update on idx 0x05 -> entry saturates at 11, then 10; prediction stays 1. Five not-taken updates from 10 -> 00, prediction 0.
- Same-cycle update (taken, idx 0x11, entry at 01) and read of idx 0x11 -> pred_taken_o=1 in that cycle. With the read at idx 0x12 instead -> idx 0x12 prediction unaffected.
- upd_valid_i=1, upd_taken_i=1, upd_pred_i=0 -> mispredict_o=1, ghr_load_o=1, ghr_taken_o=1; perf_miss_cnt_o=1 next cycle. Three rd_valid_i cycles -> perf_pred_cnt_o=3.
- Train idx 0x11 to 11, assert rst for one cycle alongside a taken update -> entry reads 00 and counters read 0 afterward.
